// File: rtl/test_status_mon_pkg.sv
// Shared constants for the end-of-test monitor: watched register indices, pass value, FSM states.
package test_status_mon_pkg;

    localparam logic [4:0]  REG_TESTNUM = 5'd3;
    localparam logic [4:0]  REG_DONE    = 5'd26;
    localparam logic [4:0]  REG_RESULT  = 5'd27;
    localparam logic [31:0] PASS_VAL    = 32'h1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2,
        ST_TOUT   = 2'd3
    } mon_state_t;

endpackage

// File: rtl/test_status_mon_timer.sv
// Saturating up-counter with a terminal-count flag at TC_VAL; used as the
// run-time cycle counter and timeout detector of the end-of-test monitor.
module test_mon_timer #(
    parameter int W      = 32,
    parameter int TC_VAL = 99
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TC_VAL));

endmodule

// File: rtl/test_status_mon.sv
// End-of-test detector snooping regfile write-back (x3 test number, x27 result, x26 done).
// Optional TEST_MON_CYCCNT_EN exposes the cycle count latched at test completion.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | program running; shadows track x3/x27; timeout armed
// ST_SETTLE | x26==1 seen; wait SETTLE_CYCLES for a late x27 write
// ST_DONE   | result sampled; pass/fail flags raised next cycle; absorbing
// ST_TOUT   | no completion within TIMEOUT_CYCLES; absorbing
module test_status_mon
    import test_status_mon_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_waddr_i,
    input  logic [31:0]      wb_wdata_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      test_num_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

`ifdef TEST_MON_CYCCNT_EN
    localparam int TMR_W = CNT_W;
`else
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;

    mon_state_t          state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                x27_pass_q;
    logic                tracking;
    logic                wr_testnum;
    logic                wr_result;
    logic                done_hit;
    logic                tmr_en;
    logic [TMR_W-1:0]    tmr_cnt;
    logic                tmr_tc;

    assign tracking   = (state == ST_RUN) || (state == ST_SETTLE);
    assign wr_testnum = wb_we_i && (wb_waddr_i == REG_TESTNUM);
    assign wr_result  = wb_we_i && (wb_waddr_i == REG_RESULT);
    assign done_hit   = wb_we_i && (wb_waddr_i == REG_DONE) && (wb_wdata_i == PASS_VAL);

`ifdef TEST_MON_CYCCNT_EN
    // Keep counting through SETTLE so the latched count reflects DONE entry.
    assign tmr_en = tracking;
`else
    assign tmr_en = (state == ST_RUN);
`endif

    test_mon_timer #(
        .W      (TMR_W),
        .TC_VAL (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk  (clk),
        .rstn (rstn),
        .en   (tmr_en),
        .cnt  (tmr_cnt),
        .tc   (tmr_tc)
    );

`ifndef TEST_MON_CYCCNT_EN
    logic unused_tmr_cnt;
    assign unused_tmr_cnt = ^tmr_cnt;
    assign cycle_cnt_o    = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RUN;
            settle_cnt <= '0;
            x27_pass_q <= 1'b0;
            test_num_o <= '0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
`ifdef TEST_MON_CYCCNT_EN
            cycle_cnt_o <= '0;
`endif
        end else begin
            // Shadows freeze once finished, so in DONE x27_pass_q already holds
            // the sampled result, including a write in the final SETTLE cycle.
            if (tracking) begin
                if (wr_testnum) test_num_o <= wb_wdata_i;
                if (wr_result)  x27_pass_q <= (wb_wdata_i == PASS_VAL);
            end

            case (state)
                ST_RUN: begin
                    if (done_hit) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                    end else if (tmr_tc) begin
                        state     <= ST_TOUT;
                        done_o    <= 1'b1;
                        timeout_o <= 1'b1;
`ifdef TEST_MON_CYCCNT_EN
                        cycle_cnt_o <= tmr_cnt;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_DONE;
`ifdef TEST_MON_CYCCNT_EN
                        cycle_cnt_o <= tmr_cnt;
`endif
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    pass_o <= x27_pass_q;
                    fail_o <= ~x27_pass_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_status_mon.sv
// Bench for test_status_mon: directed scenarios plus random write-back traffic,
// checked against an event-log model of when the test completes and with what result.
module tb_test_status_mon;

    localparam int SETTLE = 2;
    localparam int TOUT   = 100;
    localparam int CNT_W  = 32;

    logic             clk;
    logic             rstn;
    logic             wb_we_i;
    logic [4:0]       wb_waddr_i;
    logic [31:0]      wb_wdata_i;
    logic             done_o;
    logic             pass_o;
    logic             fail_o;
    logic             timeout_o;
    logic [31:0]      test_num_o;
    logic [CNT_W-1:0] cycle_cnt_o;

    test_status_mon #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb_we_i     (wb_we_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .test_num_o  (test_num_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t wlog[$];
    int  n;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Expected outputs derived from the write log: first x26==1 write no later
    // than the timeout edge starts the settle window, otherwise timeout at TOUT.
    task automatic check_all();
        int  det;
        int  freeze;
        int  fin;
        bit  res_pass;
        bit  finished;
        logic [31:0] tn;
        det = -1;
        foreach (wlog[i])
            if (det < 0 && wlog[i].a == 5'd26 && wlog[i].d == 32'h1 && wlog[i].e <= TOUT)
                det = wlog[i].e;
        if (det >= 0) begin
            freeze = det + SETTLE;
            fin    = freeze + 1;
        end else begin
            freeze = TOUT;
            fin    = TOUT;
        end
        tn       = '0;
        res_pass = 1'b0;
        foreach (wlog[i]) begin
            if (wlog[i].e <= freeze) begin
                if (wlog[i].a == 5'd3)  tn       = wlog[i].d;
                if (wlog[i].a == 5'd27) res_pass = (wlog[i].d == 32'h1);
            end
        end
        finished = (n >= fin);
        chk("done",     {31'd0, done_o},    {31'd0, finished});
        chk("pass",     {31'd0, pass_o},    {31'd0, finished && det >= 0 && res_pass});
        chk("fail",     {31'd0, fail_o},    {31'd0, finished && det >= 0 && !res_pass});
        chk("timeout",  {31'd0, timeout_o}, {31'd0, finished && det < 0});
        chk("test_num", test_num_o,         tn);
`ifdef TEST_MON_CYCCNT_EN
        chk("cycle_cnt", cycle_cnt_o, (n >= freeze) ? 32'(freeze - 1) : 32'd0);
`else
        chk("cycle_cnt", cycle_cnt_o, 32'd0);
`endif
    endtask

    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we_i    = we;
        wb_waddr_i = a;
        wb_wdata_i = d;
        @(posedge clk);
        n++;
        if (we) wlog.push_back('{n, a, d});
        #1;
        wb_we_i = 1'b0;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        wb_we_i = 1'b0;
        rstn    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        n    = 0;
        wlog.delete();
        check_all();
    endtask

    task automatic scenario_pass7();
        step(1'b1, 5'd3, 32'd7);
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd26, 32'd1);
        idle(4);
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        int          len;
        rstn       = 1'b0;
        wb_we_i    = 1'b0;
        wb_waddr_i = '0;
        wb_wdata_i = '0;
        n          = 0;

        do_reset();
        scenario_pass7();

        do_reset();
        step(1'b1, 5'd3, 32'd12);
        step(1'b1, 5'd27, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        idle(3);
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd3, 32'd99);
        idle(2);

        // late x27 one cycle after x26, in the final settle cycle, and one too late
        do_reset();
        step(1'b1, 5'd27, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        step(1'b1, 5'd27, 32'd1);
        idle(4);
        do_reset();
        step(1'b1, 5'd27, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        idle(1);
        step(1'b1, 5'd27, 32'd1);
        idle(3);
        do_reset();
        step(1'b1, 5'd27, 32'd0);
        step(1'b1, 5'd26, 32'd1);
        idle(2);
        step(1'b1, 5'd27, 32'd1);
        idle(3);

        do_reset();
        idle(TOUT + 10);

        do_reset();
        step(1'b1, 5'd26, 32'd5);
        step(1'b1, 5'd0, 32'd1);
        step(1'b1, 5'd0, 32'd1);
        idle(TOUT - 1 - n);
        step(1'b1, 5'd26, 32'd1);
        idle(5);

        do_reset();
        idle(TOUT);
        step(1'b1, 5'd26, 32'd1);
        idle(4);

        // reset pulse in the middle of SETTLE clears everything asynchronously
        do_reset();
        step(1'b1, 5'd3, 32'd7);
        step(1'b1, 5'd27, 32'd1);
        step(1'b1, 5'd26, 32'd1);
        idle(1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_done",     {31'd0, done_o},    32'd0);
        chk("rst_pass",     {31'd0, pass_o},    32'd0);
        chk("rst_fail",     {31'd0, fail_o},    32'd0);
        chk("rst_timeout",  {31'd0, timeout_o}, 32'd0);
        chk("rst_test_num", test_num_o,         32'd0);
        chk("rst_cycle",    cycle_cnt_o,        32'd0);
        do_reset();
        scenario_pass7();

        for (int r = 0; r < 8; r++) begin
            do_reset();
            len = $urandom_range(20, 120);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 4))
                    0:       ra = 5'd0;
                    1:       ra = 5'd3;
                    2:       ra = 5'd26;
                    3:       ra = 5'd27;
                    default: ra = 5'($urandom);
                endcase
                if (ra == 5'd3)       rd = $urandom;
                else if (ra == 5'd26) rd = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'($urandom_range(2, 9));
                else                  rd = 32'($urandom_range(0, 2));
                step(1'($urandom_range(0, 1)), ra, rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
